seg_scan_driver: RTL and testbench

Downstream consumer of the display-source selector. Registers the selected 8-bit digit code pair and the 14-bit display value. Converts the value to four BCD digits with a sequential double-dabble engine. Time-multiplexes six common-anode 7-segment digits from the 10 kHz system clock.

---
 rtl/seg_scan_driver.sv | 181 ++++++++++++++++++
 tb/tb_seg_scan_driver.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/seg_scan_driver.sv
// Six-digit common-anode 7-segment scan driver with sequential double-dabble BCD conversion.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zeros on numeric digits 3..1.
module seg_scan_driver #(
    parameter int SCAN_DIV = 10,
    parameter int NUM_MAX  = 9999
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  dis_dig,
    input  logic [13:0] dis_num,
    output logic [5:0]  an,
    output logic [7:0]  seg,
    output logic        conv_done
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    typedef enum logic [1:0] {S_LOAD, S_SHIFT, S_DONE} state_t;

    state_t          r_state;
    logic [3:0]      r_iter;
    logic [13:0]     r_bin;
    logic [13:0]     r_cap;
    logic [15:0]     r_bcd;
    logic [7:0]      r_hexHold;
    logic [15:0]     r_disBcd;
    logic [7:0]      r_disHex;
    logic            r_over;
    logic            r_convDone;
    logic [PW-1:0]   r_presc;
    logic [2:0]      r_idx;
    logic [5:0]      r_an;
    logic [7:0]      r_seg;

    logic [15:0]     w_adj;
    logic [29:0]     w_shift;
    logic [3:0]      w_nib;
    logic            w_dash;
    logic            w_blank;
    logic [7:0]      w_segCode;
    logic [5:0]      w_anNext;

    function automatic logic [7:0] segDecode(input logic [3:0] v);
        case (v)
            4'h0: segDecode = 8'hC0;
            4'h1: segDecode = 8'hF9;
            4'h2: segDecode = 8'hA4;
            4'h3: segDecode = 8'hB0;
            4'h4: segDecode = 8'h99;
            4'h5: segDecode = 8'h92;
            4'h6: segDecode = 8'h82;
            4'h7: segDecode = 8'hF8;
            4'h8: segDecode = 8'h80;
            4'h9: segDecode = 8'h90;
            4'hA: segDecode = 8'h88;
            4'hB: segDecode = 8'h83;
            4'hC: segDecode = 8'hC6;
            4'hD: segDecode = 8'hA1;
            4'hE: segDecode = 8'h86;
            default: segDecode = 8'h8E;
        endcase
    endfunction

    // Double-dabble step: correct each BCD nibble, then shift the combined register left.
    always_comb begin
        w_adj = r_bcd;
        for (int i = 0; i < 4; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) begin
                w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
            end
        end
        w_shift = {w_adj, r_bin} << 1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_LOAD;
            r_iter     <= 4'd0;
            r_bin      <= 14'd0;
            r_cap      <= 14'd0;
            r_bcd      <= 16'd0;
            r_hexHold  <= 8'd0;
            r_disBcd   <= 16'd0;
            r_disHex   <= 8'd0;
            r_over     <= 1'b0;
            r_convDone <= 1'b0;
        end else begin
            r_convDone <= 1'b0;
            case (r_state)
                S_LOAD: begin
                    r_bin     <= dis_num;
                    r_cap     <= dis_num;
                    r_hexHold <= dis_dig;
                    r_bcd     <= 16'd0;
                    r_iter    <= 4'd0;
                    r_state   <= S_SHIFT;
                end
                S_SHIFT: begin
                    r_bcd  <= w_shift[29:14];
                    r_bin  <= w_shift[13:0];
                    r_iter <= r_iter + 4'd1;
                    if (r_iter == 4'd13) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_disBcd   <= r_bcd;
                    r_disHex   <= r_hexHold;
                    r_over     <= ({18'd0, r_cap} > 32'(NUM_MAX));
                    r_convDone <= 1'b1;
                    r_state    <= S_LOAD;
                end
                default: r_state <= S_LOAD;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
            r_idx   <= 3'd0;
        end else if (r_presc == PW'(SCAN_DIV - 1)) begin
            r_presc <= '0;
            r_idx   <= (r_idx == 3'd5) ? 3'd0 : r_idx + 3'd1;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    // Slot content: numeric digits may be dashed (over-range) or blanked; hex digits never are.
    always_comb begin
        w_nib   = 4'd0;
        w_dash  = 1'b0;
        w_blank = 1'b0;
        case (r_idx)
            3'd0: w_nib = r_disBcd[3:0];
            3'd1: w_nib = r_disBcd[7:4];
            3'd2: w_nib = r_disBcd[11:8];
            3'd3: w_nib = r_disBcd[15:12];
            3'd4: w_nib = r_disHex[3:0];
            3'd5: w_nib = r_disHex[7:4];
            default: w_nib = 4'd0;
        endcase
        if (r_idx < 3'd4) begin
            w_dash = r_over;
        end
`ifdef LEADING_ZERO_BLANK_EN
        if (!r_over) begin
            case (r_idx)
                3'd3: w_blank = (r_disBcd[15:12] == 4'd0);
                3'd2: w_blank = (r_disBcd[15:8] == 8'd0);
                3'd1: w_blank = (r_disBcd[15:4] == 12'd0);
                default: w_blank = 1'b0;
            endcase
        end
`endif
        if (w_dash) begin
            w_segCode = 8'hBF;
        end else if (w_blank) begin
            w_segCode = 8'hFF;
        end else begin
            w_segCode = segDecode(w_nib);
        end
        w_anNext = ~(6'b000001 << r_idx);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_an  <= 6'b111111;
            r_seg <= 8'hFF;
        end else begin
            r_an  <= w_anNext;
            r_seg <= w_segCode;
        end
    end

    assign an        = r_an;
    assign seg       = r_seg;
    assign conv_done = r_convDone;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver: stimulus queues the expected six-slot pattern per commit,
// a monitor checks scan position, segment codes and conv_done timing every cycle.
module tb_seg_scan_driver;

    typedef logic [47:0] pattern_t;

    logic        clk;
    logic        rst_n;
    logic [7:0]  dis_dig;
    logic [13:0] dis_num;
    logic [5:0]  an;
    logic [7:0]  seg;
    logic        conv_done;

    int checkCount = 0;
    int failCount  = 0;
    int edgeCount;
    pattern_t expQ[$];
    pattern_t curPat;

    // Slot order in a pattern, low byte first: ones, tens, hundreds, thousands, hex lo, hex hi.
    localparam pattern_t P1234A5  = 48'h8892F9A4B099;
    localparam pattern_t P5678A5  = 48'h88929282F880;
    localparam pattern_t P9999    = 48'hB0C690909090;
    localparam pattern_t P10000   = 48'h86F9BFBFBFBF;
    localparam pattern_t P16383   = 48'hC08EBFBFBFBF;
`ifdef LEADING_ZERO_BLANK_EN
    localparam pattern_t P7       = 48'hA4A1FFFFFFF8;
    localparam pattern_t P0       = 48'hC0C0FFFFFFC0;
    localparam pattern_t P120     = 48'hF8F8FFF9A4C0;
`else
    localparam pattern_t P7       = 48'hA4A1C0C0C0F8;
    localparam pattern_t P0       = 48'hC0C0C0C0C0C0;
    localparam pattern_t P120     = 48'hF8F8C0F9A4C0;
`endif

    seg_scan_driver #(.SCAN_DIV(10), .NUM_MAX(9999)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .dis_dig   (dis_dig),
        .dis_num   (dis_num),
        .an        (an),
        .seg       (seg),
        .conv_done (conv_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) edgeCount <= 0;
        else        edgeCount <= edgeCount + 1;
    end

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        checkCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares every cycle; switches to the next queued pattern when the DUT commits.
    always @(negedge clk) begin
        int slot;
        logic [5:0] anExp;
        if (!rst_n) begin
            checkOutput("reset_an", {2'b00, an}, 8'h3F);
            checkOutput("reset_seg", seg, 8'hFF);
            checkOutput("reset_conv_done", {7'd0, conv_done}, 8'h00);
            curPat = P0;
        end else if (edgeCount > 0) begin
            slot  = ((edgeCount - 1) / 10) % 6;
            anExp = ~(6'b000001 << slot);
            checkOutput("scan_an", {2'b00, an}, {2'b00, anExp});
            checkOutput("scan_seg", seg, curPat[8*slot +: 8]);
            checkOutput("conv_done_timing", {7'd0, conv_done}, {7'd0, (edgeCount % 16) == 0});
            if (conv_done) begin
                if (expQ.size() == 0) begin
                    checkOutput("scoreboard_empty", 8'h01, 8'h00);
                end else begin
                    curPat = expQ.pop_front();
                end
            end
        end
    end

    task automatic waitCommit();
        int n = 0;
        @(negedge clk);
        while (!conv_done && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!conv_done) begin
            failCount++;
            $display("[TB] FAIL commit_timeout actual=no_conv_done required=conv_done t=%0t", $time);
        end
    endtask

    // Each waited commit queues the pattern for the following commit, which loads these inputs.
    task automatic applyStimulus(input logic [13:0] num, input logic [7:0] dig,
                                 input pattern_t pat, input int hold);
        for (int i = 0; i < hold; i++) begin
            waitCommit();
            dis_num = num;
            dis_dig = dig;
            expQ.push_back(pat);
        end
    endtask

    initial begin
        begin : watchdog
            #200000;
            failCount++;
            $display("[TB] FAIL watchdog actual=timeout required=finish");
            $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
            $finish;
        end
    end

    initial begin
        rst_n   = 1'b0;
        dis_num = 14'd1234;
        dis_dig = 8'hA5;
        curPat  = P0;
        expQ.push_back(P1234A5);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;

        applyStimulus(14'd1234,  8'hA5, P1234A5, 3);
        applyStimulus(14'd9999,  8'h3C, P9999,   4);
        applyStimulus(14'd10000, 8'hE1, P10000,  4);
        applyStimulus(14'd16383, 8'h0F, P16383,  4);
        applyStimulus(14'd7,     8'h2D, P7,      4);
        applyStimulus(14'd0,     8'h00, P0,      4);
        applyStimulus(14'd120,   8'h77, P120,    4);

        // Input change after the load edge must not reach the next commit.
        applyStimulus(14'd1234,  8'hA5, P1234A5, 1);
        repeat (3) @(posedge clk);
        #1 dis_num = 14'd5678;
        applyStimulus(14'd5678,  8'hA5, P5678A5, 4);

        // Reset in the middle of the shift phase.
        waitCommit();
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("midreset_an", {2'b00, an}, 8'h3F);
        checkOutput("midreset_seg", seg, 8'hFF);
        checkOutput("midreset_conv_done", {7'd0, conv_done}, 8'h00);
        dis_num = 14'd7;
        dis_dig = 8'h2D;
        expQ.delete();
        expQ.push_back(P7);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        applyStimulus(14'd7, 8'h2D, P7, 4);

        waitCommit();
        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
